cpu_sequencer: RTL and testbench

- Multi-cycle control FSM for the CPU core.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake and holds them in the instruction register (IR), which drives the instruction decoder.
- Sequences decode, execute, register write-back and ShowR display latch, based on the decoder's WriteBack/ShowR1 flags.
- Supports free-run, single-step and halt.

---
 rtl/cpu_sequencer.sv | 174 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Multi-cycle control FSM for the CPU core. Fetches 16-bit
//                instructions over a req/ack handshake into the instruction
//                register, then sequences decode, execute, register
//                write-back and the ShowR display latch. Supports free-run,
//                single-step and a halt instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter int          PC_WIDTH   = 8,
    parameter int          SHOW_HOLD  = 4,
    parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_Run,
    input  logic                i_Step,
    output logic [PC_WIDTH-1:0] o_ImemAddr,
    output logic                o_ImemReq,
    input  logic                i_ImemAck,
    input  logic [15:0]         i_ImemData,
    output logic [15:0]         o_Instr,
    input  logic                i_WriteBack,
    input  logic                i_ShowR1,
    output logic                o_RegWrEn,
    output logic                o_ShowLatch,
    output logic                o_Busy,
    output logic                o_Halted,
    output logic [2:0]          o_State
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The hold counter counts SHOW_HOLD-1 down to 0, one step per SHOW cycle.
    localparam int                 c_CNT_W     = (SHOW_HOLD > 1) ? $clog2(SHOW_HOLD) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(SHOW_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [PC_WIDTH-1:0] c_PC_ONE   = PC_WIDTH'(1);

    // ------------------------------------------------------------------------
    // State encoding (visible on o_State for debug)
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_SHOW   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    state_t              w_retire_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic [15:0]         r_ir;
    logic [15:0]         w_ir_nxt;
    logic [c_CNT_W-1:0]  r_hold_cnt;
    logic [c_CNT_W-1:0]  w_hold_nxt;

    // Where an instruction goes when it finishes: straight into the next
    // fetch while running, otherwise back to idle. A single step always
    // retires to idle because i_Run is low.
    assign w_retire_state = i_Run ? S_FETCH : S_IDLE;

    // ------------------------------------------------------------------------
    // State, PC, IR and hold counter registers; reset aborts any fetch.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_ir       <= 16'h0000;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, PC/IR update and SHOW hold countdown.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_hold_nxt  = r_hold_cnt;

        case (r_state)
            S_IDLE: begin
                // A step pulse is consumed here; it is never queued.
                if (i_Run || i_Step) begin
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                // Request and address stay stable until the memory acks.
                if (i_ImemAck) begin
                    w_ir_nxt = i_ImemData;
                    w_pc_nxt = r_pc + c_PC_ONE;
                    if (i_ImemData == HALT_INSTR) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_state_nxt = S_DECODE;
                    end
                end
            end

            S_DECODE: begin
                // One cycle for the decoder to settle from the new IR.
                w_state_nxt = S_EXEC;
            end

            S_EXEC: begin
                // Write-back wins when the decoder raises both flags.
                if (i_WriteBack) begin
                    w_state_nxt = S_WB;
                end else if (i_ShowR1) begin
                    w_state_nxt = S_SHOW;
                    w_hold_nxt  = c_HOLD_LOAD;
                end else begin
                    w_state_nxt = w_retire_state;
                end
            end

            S_WB: begin
                w_state_nxt = w_retire_state;
            end

            S_SHOW: begin
                if (r_hold_cnt == c_CNT_ZERO) begin
                    w_state_nxt = w_retire_state;
                end else begin
                    w_hold_nxt = r_hold_cnt - c_CNT_ONE;
                end
            end

            S_HALT: begin
                // Only reset leaves HALT.
                w_state_nxt = S_HALT;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs are decoded from registered state only, so they are glitch-free
    // relative to the inputs and drop asynchronously with reset.
    // ------------------------------------------------------------------------
    assign o_ImemAddr  = r_pc;
    assign o_ImemReq   = (r_state == S_FETCH);
    assign o_Instr     = r_ir;
    assign o_RegWrEn   = (r_state == S_WB);
    // The counter holds its load value only in the first SHOW cycle.
    assign o_ShowLatch = (r_state == S_SHOW) && (r_hold_cnt == c_HOLD_LOAD);
    assign o_Busy      = (r_state != S_IDLE) && (r_state != S_HALT);
    assign o_Halted    = (r_state == S_HALT);
    assign o_State     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sequencer
//  Description : Self-checking bench for cpu_sequencer. A per-instruction
//                plan (list of expected states) is built from the program
//                word and the chosen memory wait count; the DUT is compared
//                against that plan every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

    localparam int          PCW   = 2;
    localparam int          DEPTH = 4;
    localparam int          HOLD  = 4;
    localparam logic [15:0] HALTW = 16'hFFFF;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3,
                   ST_WB = 4, ST_SHOW = 5, ST_HALT = 6, ST_SHOW_FIRST = 8;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           run   = 1'b0;
    logic           step  = 1'b0;
    logic           ack   = 1'b0;
    logic [15:0]    data  = 16'h0000;
    logic [PCW-1:0] imem_addr;
    logic           imem_req;
    logic [15:0]    instr;
    logic           wb_flag;
    logic           show_flag;
    logic           regwr;
    logic           show_latch;
    logic           busy;
    logic           halted;
    logic [2:0]     state;

    // Decoder stand-in: bit 14 = write-back instruction, bit 15 = ShowR.
    assign wb_flag   = instr[14];
    assign show_flag = instr[15];

    cpu_sequencer #(
        .PC_WIDTH   (PCW),
        .SHOW_HOLD  (HOLD),
        .HALT_INSTR (HALTW)
    ) u_dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Run       (run),
        .i_Step      (step),
        .o_ImemAddr  (imem_addr),
        .o_ImemReq   (imem_req),
        .i_ImemAck   (ack),
        .i_ImemData  (data),
        .o_Instr     (instr),
        .i_WriteBack (wb_flag),
        .i_ShowR1    (show_flag),
        .o_RegWrEn   (regwr),
        .o_ShowLatch (show_latch),
        .o_Busy      (busy),
        .o_Halted    (halted),
        .o_State     (state)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] mem [DEPTH];
    int          q[$];
    int          m_pc       = 0;
    logic [15:0] m_ir       = 16'h0000;
    bit          m_halted   = 1'b0;
    int          m_fetches  = 0;
    int          force_wait = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] v;
        v = 16'($urandom);
        if (v == HALTW) v = 16'h7FFF;
        return v;
    endfunction

    // Expected cycle-by-cycle states of the instruction at the current PC.
    task automatic plan_instr();
        int          w;
        logic [15:0] word;
        w    = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
        word = mem[m_pc];
        for (int i = 0; i <= w; i++) q.push_back(ST_FETCH);
        if (word != HALTW) begin
            q.push_back(ST_DECODE);
            q.push_back(ST_EXEC);
            if (word[14]) begin
                q.push_back(ST_WB);
            end else if (word[15]) begin
                q.push_back(ST_SHOW_FIRST);
                for (int i = 1; i < HOLD; i++) q.push_back(ST_SHOW);
            end
        end
    endtask

    // Called at a falling edge: check outputs, drive memory, advance model
    // across the coming rising edge, then wait for the next falling edge.
    task automatic tick();
        int cur;
        int st;
        bit last_fetch;
        cur = (q.size() > 0) ? q[0] : (m_halted ? ST_HALT : ST_IDLE);
        st  = (cur == ST_SHOW_FIRST) ? ST_SHOW : cur;
        chk("state",      32'(state),      32'(st));
        chk("imem_req",   32'(imem_req),   32'(st == ST_FETCH));
        chk("regwr_en",   32'(regwr),      32'(st == ST_WB));
        chk("show_latch", 32'(show_latch), 32'(cur == ST_SHOW_FIRST));
        chk("busy",       32'(busy),       32'(st != ST_IDLE && st != ST_HALT));
        chk("halted",     32'(halted),     32'(st == ST_HALT));
        chk("imem_addr",  32'(imem_addr),  32'(m_pc));
        chk("instr",      32'(instr),      32'(m_ir));

        last_fetch = (cur == ST_FETCH) && (q.size() == 1 || q[1] != ST_FETCH);
        if (last_fetch) begin
            ack  = 1'b1;
            data = mem[m_pc];
        end else if (cur == ST_FETCH) begin
            ack  = 1'b0;
            data = 16'($urandom);
        end else begin
            // Stray acks outside FETCH must be ignored.
            ack  = 1'($urandom_range(0, 1));
            data = 16'($urandom);
        end

        if (q.size() > 0) begin
            void'(q.pop_front());
            if (last_fetch) begin
                m_ir = mem[m_pc];
                m_pc = (m_pc + 1) % DEPTH;
                m_fetches++;
                if (m_ir == HALTW) m_halted = 1'b1;
            end
            if (q.size() == 0 && !m_halted && run) plan_instr();
        end else if (!m_halted && (run || step)) begin
            plan_instr();
        end
        @(negedge clk);
    endtask

    // Reset asserted between edges; outputs must drop without a clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        ack   = 1'b0;
        #1;
        chk("rst_state", 32'(state),     32'(0));
        chk("rst_req",   32'(imem_req),  32'(0));
        chk("rst_addr",  32'(imem_addr), 32'(0));
        chk("rst_instr", 32'(instr),     32'(0));
        q.delete();
        m_pc      = 0;
        m_ir      = 16'h0000;
        m_halted  = 1'b0;
        m_fetches = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        @(negedge clk);

        // Reset then idle.
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
        do_reset();
        repeat (10) tick();

        // Single step of an ADD, zero-wait memory; a second step in WB is ignored.
        mem[0] = 16'h4123; mem[1] = 16'h0001; mem[2] = 16'h0002; mem[3] = 16'h0003;
        force_wait = 0;
        step = 1'b1;
        tick();
        step = 1'b0;
        guard = 0;
        while (!(q.size() > 0 && q[0] == ST_WB) && guard < 20) begin
            tick();
            guard++;
        end
        chk("step_reached_wb", 32'(guard < 20), 32'(1));
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (6) tick();
        chk("step_pc", 32'(imem_addr), 32'(1));

        // Run: ShowR and ADD with 2 wait states each, then halt at address 2.
        do_reset();
        mem[0] = 16'h8001; mem[1] = 16'h4002; mem[2] = HALTW; mem[3] = 16'h0000;
        force_wait = 2;
        run = 1'b1;
        guard = 0;
        while (!m_halted && guard < 60) begin
            tick();
            guard++;
        end
        chk("halt_reached", 32'(m_halted), 32'(1));
        for (int i = 0; i < 10; i++) begin
            run  = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            tick();
        end
        run  = 1'b0;
        step = 1'b0;
        chk("halt_pc", 32'(imem_addr), 32'(3));
        chk("halt_ir", 32'(instr),     32'(HALTW));

        // Run across the PC wrap, drop Run during EXEC of the fifth fetch.
        do_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_instr();
        force_wait = -1;
        run = 1'b1;
        guard = 0;
        while (!(m_fetches == 5 && q.size() > 0 && q[0] == ST_EXEC) && guard < 200) begin
            tick();
            guard++;
        end
        chk("wrap_reached", 32'(guard < 200), 32'(1));
        run = 1'b0;
        repeat (10) tick();
        chk("wrap_idle",  32'(state),     32'(0));
        chk("wrap_pc",    32'(imem_addr), 32'(1));

        // Reset while a fetch is outstanding.
        do_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_instr();
        force_wait = 3;
        run = 1'b1;
        tick();
        tick();
        chk("pre_rst_req", 32'(imem_req), 32'(1));
        do_reset();
        repeat (3) tick();

        // Randomized run/step traffic with occasional halt words.
        for (int p = 0; p < 4; p++) begin
            do_reset();
            for (int i = 0; i < DEPTH; i++)
                mem[i] = ($urandom_range(0, 7) == 0) ? HALTW : rand_instr();
            force_wait = -1;
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 9) == 0) run = ~run;
                step = ($urandom_range(0, 3) == 0);
                tick();
            end
            run  = 1'b0;
            step = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
